// File: rtl/shift_seq_ctrl.sv
// Command sequencer for an 8-bit bidirectional shift register: loads a value,
// applies up to 8 shifts with a selectable fill/rotate mode, and returns the result.
module shift_seq_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_data,
    input  logic       cmd_dir,
    input  logic [1:0] cmd_mode,
    input  logic [3:0] cmd_count,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       busy,
    output logic       sr_load,
    output logic       sr_shift,
    output logic       sr_dir,
    output logic [7:0] sr_d,
    output logic       sr_sin,
    input  logic [7:0] sr_q
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_ZERO  = 2'b00;
    localparam logic [1:0] MODE_ONES  = 2'b01;
    localparam logic [1:0] MODE_ROT   = 2'b10;
    localparam logic [1:0] MODE_ARITH = 2'b11;

    state_t     state_q, state_d;
    logic [7:0] data_q, data_d;
    logic       dir_q, dir_d;
    logic [1:0] mode_q, mode_d;
    logic [3:0] cnt_q, cnt_d;
    logic       accept;
    logic [3:0] count_clamped;

    assign accept        = cmd_valid && (state_q == ST_IDLE);
    assign count_clamped = (cmd_count > 4'd8) ? 4'd8 : cmd_count;

    // State and latched-command registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            data_q  <= 8'h00;
            dir_q   <= 1'b0;
            mode_q  <= 2'b00;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    data_d  = cmd_data;
                    dir_d   = cmd_dir;
                    mode_d  = cmd_mode;
                    cnt_d   = count_clamped;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = (cnt_q != 4'd0) ? ST_SHIFT : ST_RESP;
            end
            ST_SHIFT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic; register-facing data/direction only leave zero while a command is active
    always_comb begin
        cmd_ready = 1'b0;
        res_valid = 1'b0;
        res_data  = 8'h00;
        busy      = 1'b1;
        sr_load   = 1'b0;
        sr_shift  = 1'b0;
        sr_dir    = dir_q;
        sr_d      = data_q;
        sr_sin    = 1'b0;
        case (mode_q)
            MODE_ZERO:  sr_sin = 1'b0;
            MODE_ONES:  sr_sin = 1'b1;
            MODE_ROT:   sr_sin = dir_q ? sr_q[0] : sr_q[7];
            MODE_ARITH: sr_sin = dir_q ? sr_q[7] : 1'b0;
            default:    sr_sin = 1'b0;
        endcase
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                sr_dir    = 1'b0;
                sr_d      = 8'h00;
                sr_sin    = 1'b0;
            end
            ST_LOAD:  sr_load  = 1'b1;
            ST_SHIFT: sr_shift = 1'b1;
            ST_RESP: begin
                res_valid = 1'b1;
                res_data  = sr_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with a behavioural model of the attached shift register.
module tb_shift_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_data;
    logic       cmd_dir;
    logic [1:0] cmd_mode;
    logic [3:0] cmd_count;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       busy;
    logic       sr_load;
    logic       sr_shift;
    logic       sr_dir;
    logic [7:0] sr_d;
    logic       sr_sin;
    logic [7:0] sr_q = 8'h00;

    int checks   = 0;
    int failures = 0;

    localparam logic [22:0] RESET_VEC = {7'b1000000, 16'h0000};

    shift_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .cmd_dir   (cmd_dir),
        .cmd_mode  (cmd_mode),
        .cmd_count (cmd_count),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy),
        .sr_load   (sr_load),
        .sr_shift  (sr_shift),
        .sr_dir    (sr_dir),
        .sr_d      (sr_d),
        .sr_sin    (sr_sin),
        .sr_q      (sr_q)
    );

    always #5 clk = ~clk;

    // The shift register the controller owns
    always_ff @(posedge clk) begin
        if (sr_load) begin
            sr_q <= sr_d;
        end else if (sr_shift) begin
            sr_q <= sr_dir ? {sr_sin, sr_q[7:1]} : {sr_q[6:0], sr_sin};
        end
    end

    function automatic logic [22:0] out_vec();
        return {cmd_ready, res_valid, busy, sr_load, sr_shift, sr_dir, sr_sin, sr_d, res_data};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one command, counts strobes, measures latency from the accept edge, takes the response
    task automatic issue_cmd(input logic [7:0] d, input logic dir, input logic [1:0] mode,
                             input logic [3:0] cnt, output int lat, output int loads,
                             output int shifts, output logic [7:0] res,
                             output logic load_dir, output logic [7:0] load_d);
        int k;
        loads    = 0;
        shifts   = 0;
        load_dir = 1'b0;
        load_d   = 8'h00;
        step();
        cmd_valid = 1'b1;
        cmd_data  = d;
        cmd_dir   = dir;
        cmd_mode  = mode;
        cmd_count = cnt;
        step();
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
        k = 1;
        while (!res_valid && k < 40) begin
            if (k == 1) begin
                load_dir = sr_dir;
                load_d   = sr_d;
            end
            loads  += int'(sr_load);
            shifts += int'(sr_shift);
            step();
            k++;
        end
        lat = res_valid ? k : -1;
        res = res_data;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [22:0] v;
        rst = 1'b0;
        step();
        step();
        v = out_vec();
        checks++;
        if (v !== RESET_VEC) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=%h", v, RESET_VEC);
        end
        rst = 1'b1;
        step();
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle cmd_ready=%b busy=%b want 1/0", cmd_ready, busy);
        end
    endtask

    task automatic test_left_shift();
        int lat, loads, shifts;
        logic [7:0] res, ld;
        logic ldir;
        issue_cmd(8'h55, 1'b0, 2'b00, 4'd1, lat, loads, shifts, res, ldir, ld);
        checks++;
        if (res !== 8'hAA || lat !== 3) begin
            failures++;
            $display("FAIL left_shift res=%h lat=%0d want AA/3", res, lat);
        end
        checks++;
        if (loads !== 1 || shifts !== 1) begin
            failures++;
            $display("FAIL left_shift_strobes loads=%0d shifts=%0d want 1/1", loads, shifts);
        end
        checks++;
        if (ld !== 8'h55 || ldir !== 1'b0) begin
            failures++;
            $display("FAIL left_shift_loadpins sr_d=%h sr_dir=%b want 55/0", ld, ldir);
        end
        $display("left zero-fill d=55 cnt=1 -> %h lat=%0d", res, lat);
    endtask

    task automatic test_rotate();
        int lat, loads, shifts;
        logic [7:0] res, ld;
        logic ldir;
        issue_cmd(8'h81, 1'b1, 2'b10, 4'd1, lat, loads, shifts, res, ldir, ld);
        checks++;
        if (res !== 8'hC0 || lat !== 3) begin
            failures++;
            $display("FAIL rotate_r1 res=%h lat=%0d want C0/3", res, lat);
        end
        checks++;
        if (ldir !== 1'b1 || ld !== 8'h81) begin
            failures++;
            $display("FAIL rotate_loadpins sr_dir=%b sr_d=%h want 1/81", ldir, ld);
        end
        $display("rotate right d=81 cnt=1 -> %h lat=%0d", res, lat);
        issue_cmd(8'h81, 1'b1, 2'b10, 4'd8, lat, loads, shifts, res, ldir, ld);
        checks++;
        if (res !== 8'h81 || lat !== 10 || shifts !== 8) begin
            failures++;
            $display("FAIL rotate_r8 res=%h lat=%0d shifts=%0d want 81/10/8", res, lat, shifts);
        end
        $display("rotate right d=81 cnt=8 -> %h lat=%0d", res, lat);
        issue_cmd(8'h81, 1'b0, 2'b10, 4'd1, lat, loads, shifts, res, ldir, ld);
        checks++;
        if (res !== 8'h03) begin
            failures++;
            $display("FAIL rotate_l1 res=%h want 03", res);
        end
        $display("rotate left d=81 cnt=1 -> %h", res);
    endtask

    task automatic test_arith();
        int lat, loads, shifts;
        logic [7:0] res, ld;
        logic ldir;
        issue_cmd(8'h80, 1'b1, 2'b11, 4'd3, lat, loads, shifts, res, ldir, ld);
        checks++;
        if (res !== 8'hF0 || lat !== 5) begin
            failures++;
            $display("FAIL arith_r3 res=%h lat=%0d want F0/5", res, lat);
        end
        $display("arith right d=80 cnt=3 -> %h lat=%0d", res, lat);
        issue_cmd(8'h81, 1'b0, 2'b11, 4'd1, lat, loads, shifts, res, ldir, ld);
        checks++;
        if (res !== 8'h02) begin
            failures++;
            $display("FAIL arith_l1 res=%h want 02", res);
        end
        $display("arith left d=81 cnt=1 -> %h", res);
        issue_cmd(8'h0F, 1'b1, 2'b01, 4'd2, lat, loads, shifts, res, ldir, ld);
        checks++;
        if (res !== 8'hC3) begin
            failures++;
            $display("FAIL ones_r2 res=%h want C3", res);
        end
        $display("ones right d=0F cnt=2 -> %h", res);
    endtask

    task automatic test_count_bounds();
        int lat, loads, shifts;
        logic [7:0] res, ld;
        logic ldir;
        issue_cmd(8'h3C, 1'b0, 2'b00, 4'd0, lat, loads, shifts, res, ldir, ld);
        checks++;
        if (res !== 8'h3C || lat !== 2 || shifts !== 0 || loads !== 1) begin
            failures++;
            $display("FAIL count0 res=%h lat=%0d shifts=%0d loads=%0d want 3C/2/0/1",
                     res, lat, shifts, loads);
        end
        $display("count0 d=3C -> %h lat=%0d", res, lat);
        issue_cmd(8'h00, 1'b0, 2'b01, 4'd12, lat, loads, shifts, res, ldir, ld);
        checks++;
        if (res !== 8'hFF || lat !== 10 || shifts !== 8) begin
            failures++;
            $display("FAIL count12_clamp res=%h lat=%0d shifts=%0d want FF/10/8", res, lat, shifts);
        end
        $display("count12 ones left d=00 -> %h lat=%0d shifts=%0d", res, lat, shifts);
    endtask

    task automatic test_back_to_back();
        int k;
        int bad;
        step();
        cmd_valid = 1'b1;
        cmd_data  = 8'h55;
        cmd_dir   = 1'b0;
        cmd_mode  = 2'b00;
        cmd_count = 4'd2;
        step();
        // second command presented and held while the first is in flight
        cmd_data  = 8'h0F;
        cmd_dir   = 1'b1;
        cmd_mode  = 2'b00;
        cmd_count = 4'd1;
        k = 1;
        while (!res_valid && k < 40) begin
            step();
            k++;
        end
        checks++;
        if (k !== 4) begin
            failures++;
            $display("FAIL bp_latency got=%0d want 4", k);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (res_valid !== 1'b1 || res_data !== 8'h54 || cmd_ready !== 1'b0 || busy !== 1'b1)
                bad++;
            step();
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL bp_hold unstable_cycles=%0d want 0 (res_data=%h)", bad, res_data);
        end
        $display("backpressure first result=%h held 5 cycles", res_data);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_ready_after cmd_ready=%b busy=%b want 1/0", cmd_ready, busy);
        end
        step();
        cmd_valid = 1'b0;
        checks++;
        if (sr_load !== 1'b1 || sr_d !== 8'h0F || sr_dir !== 1'b1) begin
            failures++;
            $display("FAIL b2b_load sr_load=%b sr_d=%h sr_dir=%b want 1/0F/1", sr_load, sr_d, sr_dir);
        end
        k = 1;
        while (!res_valid && k < 40) begin
            step();
            k++;
        end
        checks++;
        if (res_data !== 8'h07 || k !== 3) begin
            failures++;
            $display("FAIL b2b_result res=%h lat=%0d want 07/3", res_data, k);
        end
        $display("back-to-back second result=%h lat=%0d", res_data, k);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    task automatic test_reset_midshift();
        int lat, loads, shifts;
        logic [7:0] res, ld;
        logic ldir;
        logic [22:0] v;
        step();
        cmd_valid = 1'b1;
        cmd_data  = 8'hFF;
        cmd_dir   = 1'b0;
        cmd_mode  = 2'b00;
        cmd_count = 4'd6;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        step();
        checks++;
        if (sr_shift !== 1'b1) begin
            failures++;
            $display("FAIL midshift_active sr_shift=%b want 1", sr_shift);
        end
        rst = 1'b0;
        step();
        v = out_vec();
        checks++;
        if (v !== RESET_VEC) begin
            failures++;
            $display("FAIL midshift_reset got=%h want=%h", v, RESET_VEC);
        end
        rst = 1'b1;
        issue_cmd(8'h3C, 1'b1, 2'b00, 4'd2, lat, loads, shifts, res, ldir, ld);
        checks++;
        if (res !== 8'h0F || lat !== 4 || shifts !== 2) begin
            failures++;
            $display("FAIL after_reset res=%h lat=%0d shifts=%0d want 0F/4/2", res, lat, shifts);
        end
        $display("after mid-shift reset d=3C right cnt=2 -> %h lat=%0d", res, lat);
    endtask

    initial begin
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
        cmd_dir   = 1'b0;
        cmd_mode  = 2'b00;
        cmd_count = 4'd0;
        res_ready = 1'b0;
        test_reset();
        test_left_shift();
        test_rotate();
        test_arith();
        test_count_bounds();
        test_back_to_back();
        test_reset_midshift();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
